// File: rtl/dram_access_arbiter_pkg.sv
// Shared definitions for the data-RAM access arbiter: owner encoding used for
// slot selection and for the one-cycle read-return tag.
package dram_access_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  localparam logic [3:0] WEN_ALL  = 4'b1111;
  localparam logic [3:0] WEN_NONE = 4'b0000;

endpackage

// File: rtl/dram_access_arbiter_if.sv
// Request/grant and RAM-side bus of the data-RAM arbiter. The master modport is
// the requester/RAM side, the slave modport is the arbiter itself.
interface dram_access_arbiter_if #(parameter int DWIDTH = 11);

  logic              cpu_req;
  logic [3:0]        cpu_we;
  logic [DWIDTH-1:0] cpu_adr;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;

  logic              dma_req;
  logic              dma_we;
  logic [DWIDTH-1:0] dma_adr;
  logic [31:0]       dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;

  logic              dbg_req;
  logic              dbg_we;
  logic [DWIDTH-1:0] dbg_adr;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;

  logic [DWIDTH-1:0] ram_adr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wen;

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output dma_req, dma_we, dma_adr, dma_wdata,
    output dbg_req, dbg_we, dbg_adr, dbg_wdata,
    input  cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, dbg_gnt, dbg_rvalid,
    input  ram_adr, ram_wdata, ram_wen
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  dma_req, dma_we, dma_adr, dma_wdata,
    input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
    output cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, dbg_gnt, dbg_rvalid,
    output ram_adr, ram_wdata, ram_wen
  );

endinterface

// File: rtl/dram_access_arbiter_starve_counter.sv
// Per-port wait counter: counts cycles a held request goes ungranted and flags
// the port as starved once the count saturates at STARVE_MAX.
module starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic starved
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] wait_cnt;

  // A dropped request or a grant both end the current wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!req || gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign starved = req && (wait_cnt == CNT_MAX);

endmodule

// File: rtl/dram_access_arbiter.sv
// Shares the single data-RAM slot per cycle between the CPU MA stage, the DMA
// engine and the debug port; CPU wins by default unless an external port starves.
module dram_access_arbiter
  import dram_access_arbiter_pkg::*;
#(
  parameter int DWIDTH     = 11,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rst_pipe,
  dram_access_arbiter_if.slave bus
);

  owner_e            sel;
  owner_e            rd_owner;
  owner_e            rd_tag;
  logic              rr_dbg;
  logic              dma_starved;
  logic              dbg_starved;
  logic [DWIDTH-1:0] mux_adr;
  logic [31:0]       mux_wdata;
  logic [3:0]        mux_wen;

  starve_counter #(.STARVE_MAX(STARVE_MAX)) u_dma_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.dma_req),
    .gnt     (sel == OWN_DMA),
    .starved (dma_starved)
  );

  starve_counter #(.STARVE_MAX(STARVE_MAX)) u_dbg_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.dbg_req),
    .gnt     (sel == OWN_DBG),
    .starved (dbg_starved)
  );

  // Starved ports pre-empt the CPU; the CPU is held off during a pipeline flush.
  always_comb begin
    sel = OWN_NONE;
    if (!rst_n)                            sel = OWN_NONE;
    else if (dma_starved && dbg_starved)   sel = rr_dbg ? OWN_DBG : OWN_DMA;
    else if (dma_starved)                  sel = OWN_DMA;
    else if (dbg_starved)                  sel = OWN_DBG;
    else if (bus.cpu_req && !rst_pipe)     sel = OWN_CPU;
    else if (bus.dma_req && bus.dbg_req)   sel = rr_dbg ? OWN_DBG : OWN_DMA;
    else if (bus.dma_req)                  sel = OWN_DMA;
    else if (bus.dbg_req)                  sel = OWN_DBG;
  end

  always_comb begin
    mux_adr   = bus.cpu_adr;
    mux_wdata = bus.cpu_wdata;
    mux_wen   = WEN_NONE;
    rd_owner  = OWN_NONE;
    case (sel)
      OWN_CPU: begin
        mux_wen  = bus.cpu_we;
        rd_owner = (bus.cpu_we == WEN_NONE) ? OWN_CPU : OWN_NONE;
      end
      OWN_DMA: begin
        mux_adr   = bus.dma_adr;
        mux_wdata = bus.dma_wdata;
        mux_wen   = bus.dma_we ? WEN_ALL : WEN_NONE;
        rd_owner  = bus.dma_we ? OWN_NONE : OWN_DMA;
      end
      OWN_DBG: begin
        mux_adr   = bus.dbg_adr;
        mux_wdata = bus.dbg_wdata;
        mux_wen   = bus.dbg_we ? WEN_ALL : WEN_NONE;
        rd_owner  = bus.dbg_we ? OWN_NONE : OWN_DBG;
      end
      default: ;
    endcase
  end

  // Pointer names the external port that wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_dbg <= 1'b0;
      rd_tag <= OWN_NONE;
    end else begin
      rd_tag <= rd_owner;
      if (sel == OWN_DMA)      rr_dbg <= 1'b1;
      else if (sel == OWN_DBG) rr_dbg <= 1'b0;
    end
  end

  assign bus.ram_adr    = mux_adr;
  assign bus.ram_wdata  = mux_wdata;
  assign bus.ram_wen    = mux_wen;
  assign bus.cpu_stall  = bus.cpu_req && rst_n && (sel != OWN_CPU);
  assign bus.dma_gnt    = (sel == OWN_DMA);
  assign bus.dbg_gnt    = (sel == OWN_DBG);
  // A flush kills a CPU load returning this cycle; external returns still land.
  assign bus.cpu_rvalid = (rd_tag == OWN_CPU) && !rst_pipe;
  assign bus.dma_rvalid = (rd_tag == OWN_DMA);
  assign bus.dbg_rvalid = (rd_tag == OWN_DBG);

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Directed self-checking bench for dram_access_arbiter: priority, round-robin,
// starvation promotion, read-return tagging, pipeline flush and async reset.
module tb_dram_access_arbiter;

  localparam int DWIDTH = 11;
  localparam logic [DWIDTH-1:0] CPU_ADR = 11'h010;
  localparam logic [DWIDTH-1:0] DMA_ADR = 11'h123;
  localparam logic [DWIDTH-1:0] DBG_ADR = 11'h7AB;
  localparam logic [31:0] CPU_WD = 32'hC0C0_0001;
  localparam logic [31:0] DMA_WD = 32'hDDDD_0002;
  localparam logic [31:0] DBG_WD = 32'hBEEF_0003;

  logic clk;
  logic rst_n;
  logic rst_pipe;
  int   checks;
  int   errors;

  dram_access_arbiter_if #(.DWIDTH(DWIDTH)) bus ();

  dram_access_arbiter #(.DWIDTH(DWIDTH), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_pipe (rst_pipe),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status bits: {cpu_stall, dma_gnt, dbg_gnt, cpu_rvalid, dma_rvalid, dbg_rvalid}
  function automatic logic [5:0] status();
    return {bus.cpu_stall, bus.dma_gnt, bus.dbg_gnt,
            bus.cpu_rvalid, bus.dma_rvalid, bus.dbg_rvalid};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle's requests on the falling edge, leaving time to settle.
  task automatic applyStimulus(input logic c_req, input logic [3:0] c_we,
                               input logic d_req, input logic d_we,
                               input logic g_req, input logic g_we,
                               input logic flush);
    @(negedge clk);
    bus.cpu_req = c_req;
    bus.cpu_we  = c_we;
    bus.dma_req = d_req;
    bus.dma_we  = d_we;
    bus.dbg_req = g_req;
    bus.dbg_we  = g_we;
    rst_pipe    = flush;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    rst_pipe = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 4'b0011; bus.cpu_adr = CPU_ADR; bus.cpu_wdata = CPU_WD;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1;    bus.dma_adr = DMA_ADR; bus.dma_wdata = DMA_WD;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0;    bus.dbg_adr = DBG_ADR; bus.dbg_wdata = DBG_WD;

    // Reset holds every grant, stall and write enable low even with requests up.
    @(negedge clk); @(negedge clk); #1;
    checkOutput("reset_status", 32'(status()), 32'h00);
    checkOutput("reset_wen", 32'(bus.ram_wen), 32'h0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // DMA and debug reads back to back: alternate starting with DMA.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 4'b0000, 1, 0, 1, 0, 0);
      if (i % 2 == 1) begin
        checkOutput("rr_odd_status", 32'(status()), (i == 1) ? 32'h10 : 32'h11);
        checkOutput("rr_odd_adr", 32'(bus.ram_adr), 32'(DMA_ADR));
      end else begin
        checkOutput("rr_even_status", 32'(status()), 32'h0A);
        checkOutput("rr_even_adr", 32'(bus.ram_adr), 32'(DBG_ADR));
      end
    end
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
    checkOutput("rr_tail_status", 32'(status()), 32'h01);
    checkOutput("idle_adr", 32'(bus.ram_adr), 32'(CPU_ADR));
    checkOutput("idle_wen", 32'(bus.ram_wen), 32'h0);

    // CPU load alone.
    applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0);
    checkOutput("cpu_load_status", 32'(status()), 32'h00);
    checkOutput("cpu_load_adr", 32'(bus.ram_adr), 32'h010);
    checkOutput("cpu_load_wen", 32'(bus.ram_wen), 32'h0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
    checkOutput("cpu_load_rvalid", 32'(status()), 32'h04);

    // CPU store beats a fresh DMA read; DMA takes the next free cycle.
    applyStimulus(1, 4'b0011, 1, 0, 0, 0, 0);
    checkOutput("cpu_store_status", 32'(status()), 32'h00);
    checkOutput("cpu_store_wen", 32'(bus.ram_wen), 32'h3);
    checkOutput("cpu_store_wdata", bus.ram_wdata, CPU_WD);
    applyStimulus(0, 4'b0000, 1, 0, 0, 0, 0);
    checkOutput("dma_late_status", 32'(status()), 32'h10);
    checkOutput("dma_late_adr", 32'(bus.ram_adr), 32'(DMA_ADR));
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
    checkOutput("dma_late_rvalid", 32'(status()), 32'h02);

    // CPU every cycle with DMA write held: DMA pre-empts on the 5th cycle, twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 5; i++) begin
        applyStimulus(1, 4'b0001, 1, 1, 0, 0, 0);
        if (i < 5) begin
          checkOutput("starve_wait_status", 32'(status()), 32'h00);
          checkOutput("starve_wait_wen", 32'(bus.ram_wen), 32'h1);
        end else begin
          checkOutput("starve_hit_status", 32'(status()), 32'h30);
          checkOutput("starve_hit_wen", 32'(bus.ram_wen), 32'hF);
          checkOutput("starve_hit_wdata", bus.ram_wdata, DMA_WD);
        end
      end
    end
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
    checkOutput("starve_tail_status", 32'(status()), 32'h00);

    // CPU load then flush: CPU return dropped, DMA read in flush cycle returns.
    applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0);
    checkOutput("flush_load_status", 32'(status()), 32'h00);
    applyStimulus(1, 4'b0000, 1, 0, 0, 0, 1);
    checkOutput("flush_status", 32'(status()), 32'h30);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
    checkOutput("flush_dma_rvalid", 32'(status()), 32'h02);

    // Debug read granted, then async reset before its data returns.
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 0);
    checkOutput("dbg_read_status", 32'(status()), 32'h08);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_status", 32'(status()), 32'h00);
    checkOutput("rst_mid_wen", 32'(bus.ram_wen), 32'h0);
    @(negedge clk); #1;
    checkOutput("rst_hold_status", 32'(status()), 32'h00);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checkOutput("rst_after_status", 32'(status()), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
